// File: rtl/mem_access_if.sv
// Data-memory request/valid bus between the mem_access stage (master) and the memory (slave).
interface mem_access_if;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_valid;

   modport master (
      output mem_en, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata, mem_valid
   );

   modport slave (
      input  mem_en, mem_wr, mem_addr, mem_wdata,
      output mem_rdata, mem_valid
   );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: word-aligned LW/SW over a variable-latency request/valid
// bus, stalling the PC while an access is outstanding and abandoning it after TIMEOUT waits.
module mem_access #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [15:0]         aluResult,
   input  logic [15:0]         writeData,
   input  logic                MemRead,
   input  logic                MemWrite,
   input  logic                MemtoReg,
   mem_access_if.master        mem,
   output logic                stall,
   output logic [15:0]         wb_data,
   output logic                err
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q;
   logic [15:0] rdata_q;
   logic        req;
   logic        start;
   logic        complete;
   logic        expire;

   assign req = MemRead | MemWrite;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d  = state_q;
      start    = 1'b0;
      complete = 1'b0;
      expire   = 1'b0;
      stall    = 1'b0;
      case (state_q)
         IDLE: begin
            stall = req;
            if (req) begin
               start   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            stall   = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            stall = 1'b1;
            // A completion in the last permitted wait cycle beats the timeout.
            if (mem.mem_valid) begin
               complete = 1'b1;
               state_d  = DONE;
            end else if (cnt_q == LAST_WAIT) begin
               expire  = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses <= so every register updates from pre-edge values.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem.mem_en    <= 1'b0;
         mem.mem_wr    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         cnt_q         <= '0;
         rdata_q       <= '0;
         err           <= 1'b0;
      end else begin
         mem.mem_en <= start;
         if (start) begin
            mem.mem_addr  <= {aluResult[15:1], 1'b0};
            mem.mem_wdata <= writeData;
            mem.mem_wr    <= MemWrite;
         end

         if (start)
            cnt_q <= '0;
         else if (state_q == WAIT && cnt_q != 8'hFF)
            cnt_q <= cnt_q + 8'd1;

         if (complete && !mem.mem_wr)
            rdata_q <= mem.mem_rdata;
         else if (expire)
            rdata_q <= '0;

         // Conflicting LW+SW decode proceeds as a store but is still flagged.
         if (expire || (start && MemRead && MemWrite))
            err <= 1'b1;
      end
   end

   assign wb_data = MemtoReg ? rdata_q : aluResult;

endmodule
